// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: widths, reset PC, canonical NOP and the IF/ID record.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic            valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection for fetch: stall hold, redirect to branch/jal/jalr target, or sequential.
module next_pc_sel #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] id_pc,
  input  logic            id_valid,
  input  logic            stall,
  input  logic            pcsrc,
  input  logic            jalre,
  input  logic [XLEN-1:0] immext,
  input  logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] next_pc,
  output logic            flush,
  output logic            misalign
);

  logic [XLEN-1:0] target;

  always_comb begin
    target   = jalre ? alu_result : (id_pc + immext);
    // A bubble in decode carries no decision, so it must never redirect.
    flush    = pcsrc & id_valid & ~stall;
    misalign = flush & target[1];
    if (stall) begin
      next_pc = pc;
    end else if (flush) begin
      next_pc = target & ~XLEN'(3);
    end else begin
      next_pc = pc + XLEN'(4);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and delivered-instruction counter.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            pcsrc,
  input  logic            jalre,
  input  logic [XLEN-1:0] immext,
  input  logic [XLEN-1:0] alu_result,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic            misalign_err,
  output logic [31:0]     fetch_count
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] next_pc;
  logic            flush;
  logic            misalign;

  next_pc_sel #(
    .XLEN(XLEN)
  ) u_next_pc_sel (
    .pc        (pc_q),
    .id_pc     (id_pc),
    .id_valid  (id_valid),
    .stall     (stall),
    .pcsrc     (pcsrc),
    .jalre     (jalre),
    .immext    (immext),
    .alu_result(alu_result),
    .next_pc   (next_pc),
    .flush     (flush),
    .misalign  (misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      id_valid     <= 1'b0;
      id_instr     <= NOP_INSTR;
      id_pc        <= '0;
      id_pc_plus4  <= XLEN'(4);
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      pc_q         <= next_pc;
      misalign_err <= misalign;
      if (!stall) begin
        if (flush) begin
          // Squash the wrong-path word; id_pc/id_pc_plus4 keep their last values.
          id_valid <= 1'b0;
          id_instr <= NOP_INSTR;
        end else begin
          id_valid    <= 1'b1;
          id_instr    <= imem_rdata;
          id_pc       <= pc_q;
          id_pc_plus4 <= pc_q + XLEN'(4);
          fetch_count <= fetch_count + 32'd1;
        end
      end
    end
  end

  assign imem_addr = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: spec-level reference model checked every cycle plus directed literals.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_w;
  logic [31:0] imem_addr, imem_rdata;
  logic        stall, pcsrc, jalre;
  logic [31:0] immext, alu_result;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, id_pc_plus4;
  logic        misalign_err;
  logic [31:0] fetch_count;

  logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pc_plus4, w_count;
  logic        w_valid, w_mis;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  // Memory image: word at address A is 0x11 * (A/4 + 1).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h11 * ((a >> 2) + 32'd1);
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign w_rdata    = mem_word(w_addr);

  fetch_stage u_dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .pcsrc       (pcsrc),
    .jalre       (jalre),
    .immext      (immext),
    .alu_result  (alu_result),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .misalign_err(misalign_err),
    .fetch_count (fetch_count)
  );

  fetch_stage #(
    .RESET_PC(32'hFFFF_FFF8)
  ) u_wrap (
    .clk         (clk),
    .rst         (rst_w),
    .imem_addr   (w_addr),
    .imem_rdata  (w_rdata),
    .stall       (1'b0),
    .pcsrc       (1'b0),
    .jalre       (1'b0),
    .immext      (32'h0),
    .alu_result  (32'h0),
    .id_valid    (w_valid),
    .id_instr    (w_instr),
    .id_pc       (w_pc),
    .id_pc_plus4 (w_pc_plus4),
    .misalign_err(w_mis),
    .fetch_count (w_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the stage must present, derived from the fetch rules.
  logic [31:0] m_pc, m_instr, m_id_pc, m_plus4, m_cnt, tgt;
  logic        m_valid, m_mis;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 32'h0; m_valid = 1'b0; m_instr = NOP; m_id_pc = 32'h0;
      m_plus4 = 32'd4; m_cnt = 32'h0; m_mis = 1'b0;
    end else if (stall) begin
      m_mis = 1'b0;
    end else if (pcsrc && m_valid) begin
      tgt     = jalre ? alu_result : m_id_pc + immext;
      m_mis   = tgt[1];
      m_pc    = {tgt[31:2], 2'b00};
      m_valid = 1'b0;
      m_instr = NOP;
    end else begin
      m_valid = 1'b1;
      m_instr = mem_word(m_pc);
      m_id_pc = m_pc;
      m_plus4 = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      m_cnt   = m_cnt + 32'd1;
      m_mis   = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_addr", imem_addr, m_pc);
      check("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
      check("id_instr", id_instr, m_instr);
      check("id_pc", id_pc, m_id_pc);
      check("id_pc_plus4", id_pc_plus4, m_plus4);
      check("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
      check("fetch_count", fetch_count, m_cnt);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rst_w = 1'b1; stall = 1'b0; pcsrc = 1'b0; jalre = 1'b0;
    immext = 32'h0; alu_result = 32'h0;
    tick(2);
    chk_en = 1'b1;
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'b0, id_valid}, 32'h0);
    check("rst_instr", id_instr, NOP);
    check("rst_plus4", id_pc_plus4, 32'd4);
    check("rst_count", fetch_count, 32'h0);
    rst = 1'b0;

    // Sequential fetch
    tick(3);
    check("seq_id_pc", id_pc, 32'h8);
    check("seq_instr", id_instr, 32'h33);
    check("seq_count", fetch_count, 32'd3);

    // bne taken from id_pc 8 back to 0
    pcsrc = 1'b1; immext = 32'hFFFF_FFF8;
    tick(1);
    check("bne_bubble", {31'b0, id_valid}, 32'h0);
    check("bne_addr", imem_addr, 32'h0);
    pcsrc = 1'b0; immext = 32'h0;
    tick(1);
    check("bne_id_pc", id_pc, 32'h0);
    check("bne_instr", id_instr, 32'h11);
    check("bne_count", fetch_count, 32'd4);

    // jalr to misaligned 0x103, then to 0x101
    jalre = 1'b1; pcsrc = 1'b1; alu_result = 32'h103;
    tick(1);
    check("jalr_addr", imem_addr, 32'h100);
    check("jalr_mis", {31'b0, misalign_err}, 32'h1);
    pcsrc = 1'b0;
    tick(1);
    check("jalr_mis_pulse", {31'b0, misalign_err}, 32'h0);
    check("jalr_instr", id_instr, 32'h451);
    pcsrc = 1'b1; alu_result = 32'h101;
    tick(1);
    check("jalr2_addr", imem_addr, 32'h100);
    check("jalr2_mis", {31'b0, misalign_err}, 32'h0);
    pcsrc = 1'b0; jalre = 1'b0; alu_result = 32'h0;
    tick(1);

    // Stall with pcsrc held: everything frozen, then redirect when stall drops
    stall = 1'b1; pcsrc = 1'b1; immext = 32'h40;
    tick(3);
    check("stall_addr", imem_addr, 32'h104);
    check("stall_id_pc", id_pc, 32'h100);
    check("stall_count", fetch_count, 32'd6);
    stall = 1'b0;
    tick(1);
    check("unstall_addr", imem_addr, 32'h140);
    // pcsrc still high against a bubble: no redirect
    tick(1);
    check("bubble_noredir", imem_addr, 32'h144);
    check("bubble_id_pc", id_pc, 32'h140);
    pcsrc = 1'b0; immext = 32'h0;
    tick(2);

    // Reset together with stall and a misaligned redirect
    rst = 1'b1; stall = 1'b1; pcsrc = 1'b1; jalre = 1'b1; alu_result = 32'h103;
    tick(1);
    check("rstmix_addr", imem_addr, 32'h0);
    check("rstmix_valid", {31'b0, id_valid}, 32'h0);
    check("rstmix_count", fetch_count, 32'h0);
    check("rstmix_mis", {31'b0, misalign_err}, 32'h0);
    rst = 1'b0; stall = 1'b0; pcsrc = 1'b0; jalre = 1'b0; alu_result = 32'h0;
    tick(2);

    // Address wrap on the second instance
    check("wrap_rst_addr", w_addr, 32'hFFFF_FFF8);
    rst_w = 1'b0;
    tick(1);
    check("wrap_id_pc0", w_pc, 32'hFFFF_FFF8);
    check("wrap_addr1", w_addr, 32'hFFFF_FFFC);
    tick(1);
    check("wrap_id_pc1", w_pc, 32'hFFFF_FFFC);
    check("wrap_plus4", w_pc_plus4, 32'h0);
    check("wrap_addr2", w_addr, 32'h0);
    tick(1);
    check("wrap_id_pc2", w_pc, 32'h0);
    check("wrap_count", w_count, 32'd3);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
